sdma_multi_ch_req_ctrl: RTL
===========================

// Module: sdma_multi_ch_req_ctrl
// PURPOSE
//  Per-channel SDMA request/handshake controller; successor to the single-channel I2S DMA request logic.
//  Tracks words pending in each channel's receive FIFO, issues burst (Req) or single (Sreq) requests to the
//  S3 SDMA, and raises sticky DMA-done and overflow interrupts per channel. Sits between the I2S/sample RX
//  front ends and the cell-macro SDMA_Req/Sreq/Done/Active ports, all in the WB_CLK domain.
// PARAMETERS
//  NUM_CH  4    number of independent channels (1..4, one SDMA channel each)
//  DEPTH   256  FIFO depth per channel in words; level saturates here
//  BURST   64   words moved per burst request; 1 <= BURST <= DEPTH
//  CW      $clog2(DEPTH+1) level counter width (localparam, derived, not overridable)
// PORTS
//  WB_CLK        in   1          single clock
//  WB_RST        in   1          synchronous, active-high reset
//  ch_en_i       in   NUM_CH     channel enable
//  push_i        in   NUM_CH     1-cycle pulse: one word written into channel FIFO
//  flush_i       in   NUM_CH     level: permit single-word requests to drain below BURST
//  SDMA_Active_i in   NUM_CH     SDMA has accepted request, transfer in progress
//  SDMA_Done_i   in   NUM_CH     1-cycle pulse: transfer complete
//  intr_clr_i    in   NUM_CH     1-cycle pulse: clear sticky interrupts of channel
//  SDMA_Req_o    out  NUM_CH     burst request
//  SDMA_Sreq_o   out  NUM_CH     single-word request
//  level_o       out  NUM_CH*CW  words pending, channel n at [n*CW +: CW]
//  dma_intr_o    out  NUM_CH     sticky: a transfer completed
//  ovf_intr_o    out  NUM_CH     sticky: push while level==DEPTH (word dropped)
// BEHAVIOUR
//  Reset: all outputs 0, all levels 0, all FSMs IDLE. Reset mid-transfer aborts; later Done ignored (IDLE).
//  Level per cycle: next = level + (push && level<DEPTH) - (Done in ACT ? xfer_size : 0); push+Done same
//   cycle both apply. xfer_size latched on request: BURST for Req, 1 for Sreq. Never underflows.
//  push at level==DEPTH: level unchanged, ovf_intr set (registered, next cycle).
//  Per-channel FSM (registered outputs, 1-cycle latency from condition to Req/Sreq):
//   IDLE: ch_en && level>=BURST -> REQ_B (Req=1); else ch_en && flush && level>=1 -> REQ_S (Sreq=1).
//   REQ_B/REQ_S: hold request until Active_i=1 -> ACT, request drops same edge. ch_en=0 here -> IDLE, drop req.
//   ACT: wait Done_i -> IDLE, subtract xfer_size, set dma_intr. ch_en=0 in ACT does not abort; finishes.
//   Done_i outside ACT ignored. Active_i and Done_i in same cycle while in REQ: treat as accept+complete.
//  Req and Sreq of one channel never high together. Channels fully independent, no arbitration.
//  Interrupts: set has priority over simultaneous intr_clr_i.
//  Back-to-back: IDLE re-evaluates the cycle after Done, so new Req may appear 2 cycles after Done.
// TESTING
//  1. 64 pushes, ch_en=1, BURST=64 -> Req high 1 cycle after 64th push; Active -> Req low; Done -> level 0, dma_intr=1.
//  2. 10 pushes, flush=1 -> Sreq; 10 Active/Done handshakes -> level 0, Req never asserted.
//  3. 257 pushes, ch_en=0 -> level=256, ovf_intr=1; intr_clr -> ovf_intr 0 next cycle.
//  4. In ACT, push and Done same cycle at level 70 -> level 7; ch_en dropped in ACT still completes.
//  5. Four channels concurrent, staggered pushes/handshakes -> independent Req/level per channel, no crosstalk.
//  6. WB_RST asserted in ACT, then Done pulse -> outputs 0, level 0, Done ignored.

Source files
------------

// File: rtl/sdma_multi_ch_req_ctrl.sv
// Per-channel SDMA request controller: tracks RX FIFO fill level, issues burst/single
// requests, and keeps sticky completion and overflow interrupts for each channel.
module sdma_multi_ch_req_ctrl #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned BURST  = 64,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST,
    input  logic [NUM_CH-1:0]    ch_en_i,
    input  logic [NUM_CH-1:0]    push_i,
    input  logic [NUM_CH-1:0]    flush_i,
    input  logic [NUM_CH-1:0]    SDMA_Active_i,
    input  logic [NUM_CH-1:0]    SDMA_Done_i,
    input  logic [NUM_CH-1:0]    intr_clr_i,
    output logic [NUM_CH-1:0]    SDMA_Req_o,
    output logic [NUM_CH-1:0]    SDMA_Sreq_o,
    output logic [NUM_CH*CW-1:0] level_o,
    output logic [NUM_CH-1:0]    dma_intr_o,
    output logic [NUM_CH-1:0]    ovf_intr_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReqB,
        StReqS,
        StAct
    } state_e;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e        state_q;
        logic [CW-1:0] level_q;
        logic [CW-1:0] level_d;
        logic [CW-1:0] level_inc;
        logic [CW-1:0] xfer;
        logic [CW-1:0] dec;
        logic          size_burst_q;
        logic          req_q;
        logic          sreq_q;
        logic          dma_q;
        logic          ovf_q;
        logic          at_full;
        logic          inc;
        logic          in_req;
        logic          complete;

        always_comb begin
            at_full   = (level_q == CW'(DEPTH));
            inc       = push_i[c] && !at_full;
            xfer      = size_burst_q ? CW'(BURST) : CW'(1);
            in_req    = (state_q == StReqB) || (state_q == StReqS);
            // Accept and completion in the same cycle count as a finished transfer.
            complete  = SDMA_Done_i[c] && ((state_q == StAct) || (in_req && SDMA_Active_i[c]));
            level_inc = level_q + CW'(inc);
            dec       = complete ? xfer : '0;
            level_d   = (level_inc >= dec) ? (level_inc - dec) : '0;
        end

        always_ff @(posedge WB_CLK) begin
            if (WB_RST) begin
                state_q      <= StIdle;
                level_q      <= '0;
                size_burst_q <= 1'b0;
                req_q        <= 1'b0;
                sreq_q       <= 1'b0;
                dma_q        <= 1'b0;
                ovf_q        <= 1'b0;
            end else begin
                level_q <= level_d;
                dma_q   <= complete || (dma_q && !intr_clr_i[c]);
                ovf_q   <= (push_i[c] && at_full) || (ovf_q && !intr_clr_i[c]);
                unique case (state_q)
                    StIdle: begin
                        if (ch_en_i[c] && (level_q >= CW'(BURST))) begin
                            state_q      <= StReqB;
                            req_q        <= 1'b1;
                            size_burst_q <= 1'b1;
                        end else if (ch_en_i[c] && flush_i[c] && (level_q != '0)) begin
                            state_q      <= StReqS;
                            sreq_q       <= 1'b1;
                            size_burst_q <= 1'b0;
                        end
                    end
                    StReqB, StReqS: begin
                        // An accepted request proceeds even if the channel is disabled that cycle.
                        if (SDMA_Active_i[c]) begin
                            state_q <= SDMA_Done_i[c] ? StIdle : StAct;
                            req_q   <= 1'b0;
                            sreq_q  <= 1'b0;
                        end else if (!ch_en_i[c]) begin
                            state_q <= StIdle;
                            req_q   <= 1'b0;
                            sreq_q  <= 1'b0;
                        end
                    end
                    StAct: begin
                        if (SDMA_Done_i[c]) begin
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                        sreq_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign SDMA_Req_o[c]          = req_q;
        assign SDMA_Sreq_o[c]         = sreq_q;
        assign dma_intr_o[c]          = dma_q;
        assign ovf_intr_o[c]          = ovf_q;
        assign level_o[c*CW +: CW]    = level_q;
    end

endmodule
